// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate enable at sysclk/2, h/v counters, and
// registered sync/colour outputs that trail display_addr by one pixel period.
module vga_timing_gen #(
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525
) (
  input  logic        sysclk,
  input  logic        rst_n,
  input  logic [2:0]  display_data,
  output logic [19:0] display_addr,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic [2:0]  vga_rgb,
  output logic        frame_start
);

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_SYNC_E = 11'(H_SYNC);
  localparam logic [10:0] V_SYNC_E = 11'(V_SYNC);
  localparam logic [10:0] H_ACT_LO = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_ACT_HI = 11'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [10:0] V_ACT_LO = 11'(V_SYNC + V_BP);
  localparam logic [10:0] V_ACT_HI = 11'(V_SYNC + V_BP + V_ACTIVE);

  logic       pix_en_q, pix_en_d;
  logic [9:0] h_count_q, h_count_d;
  logic [9:0] v_count_q, v_count_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic [2:0] rgb_q, rgb_d;
  logic       frame_start_q, frame_start_d;

  logic [10:0] h_ext, v_ext;
  logic        active;

  assign h_ext  = {1'b0, h_count_q};
  assign v_ext  = {1'b0, v_count_q};
  assign active = (h_ext >= H_ACT_LO) && (h_ext < H_ACT_HI) &&
                  (v_ext >= V_ACT_LO) && (v_ext < V_ACT_HI);

  always_comb begin
    pix_en_d      = ~pix_en_q;
    h_count_d     = h_count_q;
    v_count_d     = v_count_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    rgb_d         = rgb_q;
    frame_start_d = 1'b0;
    if (pix_en_q) begin
      // Outputs describe the pixel the counters point at before this step.
      hsync_d       = !(h_ext < H_SYNC_E);
      vsync_d       = !(v_ext < V_SYNC_E);
      rgb_d         = active ? display_data : 3'b000;
      frame_start_d = (h_count_q == 10'd0) && (v_count_q == 10'd0);
      if (h_count_q == H_LAST) begin
        h_count_d = 10'd0;
        v_count_d = (v_count_q == V_LAST) ? 10'd0 : v_count_q + 10'd1;
      end else begin
        h_count_d = h_count_q + 10'd1;
      end
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      pix_en_q      <= 1'b0;
      h_count_q     <= 10'd0;
      v_count_q     <= 10'd0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      rgb_q         <= 3'b000;
      frame_start_q <= 1'b0;
    end else begin
      pix_en_q      <= pix_en_d;
      h_count_q     <= h_count_d;
      v_count_q     <= v_count_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign display_addr = {h_count_q, v_count_q};
  assign vga_hsync    = hsync_q;
  assign vga_vsync    = vsync_q;
  assign vga_rgb      = rgb_q;
  assign frame_start  = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench: a small-raster instance checked every sysclk against a
// pixel-index model, plus a default-timing instance for sync edge spacing.
module tb_vga_timing_gen;

  localparam int SHS = 4, SHB = 3, SHA = 10, SHT = 20;
  localparam int SVS = 2, SVB = 2, SVA = 5,  SVT = 12;
  localparam int SFRM = SHT * SVT;
  localparam int HOLD_LO = 3 * SFRM, HOLD_HI = 4 * SFRM;

  logic        sysclk = 1'b0;
  logic        rst_n;
  logic [2:0]  dd_s, dd_d;
  logic [19:0] s_addr, d_addr;
  logic        s_hs, s_vs, s_fs, d_hs, d_vs, d_fs;
  logic [2:0]  s_rgb, d_rgb;

  always #5 sysclk = ~sysclk;

  vga_timing_gen #(
    .H_SYNC(SHS), .H_BP(SHB), .H_ACTIVE(SHA), .H_TOTAL(SHT),
    .V_SYNC(SVS), .V_BP(SVB), .V_ACTIVE(SVA), .V_TOTAL(SVT)
  ) u_small (
    .sysclk(sysclk), .rst_n(rst_n), .display_data(dd_s),
    .display_addr(s_addr), .vga_hsync(s_hs), .vga_vsync(s_vs),
    .vga_rgb(s_rgb), .frame_start(s_fs)
  );

  vga_timing_gen u_dflt (
    .sysclk(sysclk), .rst_n(rst_n), .display_data(dd_d),
    .display_addr(d_addr), .vga_hsync(d_hs), .vga_vsync(d_vs),
    .vga_rgb(d_rgb), .frame_start(d_fs)
  );

  int pass_cnt = 0, chk_cnt = 0;
  int n, hold_cnt, fs_cnt;
  int d_f1, d_f2, d_r1, d_vf1, d_vr1;
  logic d_hs_prev, d_vs_prev;
  logic [2:0] drv, exp_rgb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (n=%0d)", tag, obs, exp, n);
  endtask

  function automatic bit act(input int q);
    int h, v;
    h = q % SHT;
    v = (q / SHT) % SVT;
    return (h >= SHS + SHB) && (h < SHS + SHB + SHA) &&
           (v >= SVS + SVB) && (v < SVS + SVB + SVA);
  endfunction

  // Colour for the pixel the counters currently point at; X outside active.
  function automatic logic [2:0] pick(input int q);
    if (q >= HOLD_LO && q < HOLD_HI) return 3'b101;
    if (act(q)) return 3'($urandom);
    if ($urandom_range(3) == 0) return 3'bxxx;
    return 3'($urandom);
  endfunction

  task automatic start_run();
    n = 0; hold_cnt = 0; fs_cnt = 0; exp_rgb = 3'b000;
    d_f1 = -1; d_f2 = -1; d_r1 = -1; d_vf1 = -1; d_vr1 = -1;
    d_hs_prev = d_hs; d_vs_prev = d_vs;
    drv = pick(0);
    dd_s = drv;
  endtask

  task automatic run(input int cycles);
    int p;
    logic e_hs, e_vs, e_fs;
    logic [19:0] e_addr;
    for (int c = 0; c < cycles; c++) begin
      @(posedge sysclk);
      n++;
      @(negedge sysclk);
      p = n / 2;
      if (n % 2 == 0) begin
        exp_rgb = act(p - 1) ? drv : 3'b000;
        if (p - 1 >= HOLD_LO && p - 1 < HOLD_HI && s_rgb === 3'b101) hold_cnt++;
      end
      e_hs   = (p >= 1) ? !(((p - 1) % SHT) < SHS) : 1'b1;
      e_vs   = (p >= 1) ? !((((p - 1) / SHT) % SVT) < SVS) : 1'b1;
      e_fs   = (n % 2 == 0) && (p >= 1) && ((p - 1) % SFRM == 0);
      e_addr = {10'(p % SHT), 10'((p / SHT) % SVT)};
      if (s_fs === 1'b1) fs_cnt++;
      chk("addr", 32'(s_addr), 32'(e_addr));
      chk("hsync", 32'(s_hs), 32'(e_hs));
      chk("vsync", 32'(s_vs), 32'(e_vs));
      chk("rgb", 32'(s_rgb), 32'(exp_rgb));
      chk("frame_start", 32'(s_fs), 32'(e_fs));
      if (d_hs_prev === 1'b1 && d_hs === 1'b0) begin
        if (d_f1 < 0) d_f1 = n; else if (d_f2 < 0) d_f2 = n;
      end
      if (d_hs_prev === 1'b0 && d_hs === 1'b1 && d_r1 < 0) d_r1 = n;
      if (d_vs_prev === 1'b1 && d_vs === 1'b0 && d_vf1 < 0) d_vf1 = n;
      if (d_vs_prev === 1'b0 && d_vs === 1'b1 && d_vr1 < 0) d_vr1 = n;
      d_hs_prev = d_hs;
      d_vs_prev = d_vs;
      if (n == 2 * (800 + 300)) chk("dflt_addr_h300_v1", 32'(d_addr), 32'h4B001);
      drv = pick(p);
      dd_s = drv;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_s_addr"}, 32'(s_addr), 32'h0);
    chk({tag, "_s_hs"}, 32'(s_hs), 32'h1);
    chk({tag, "_s_vs"}, 32'(s_vs), 32'h1);
    chk({tag, "_s_rgb"}, 32'(s_rgb), 32'h0);
    chk({tag, "_s_fs"}, 32'(s_fs), 32'h0);
    chk({tag, "_d_addr"}, 32'(d_addr), 32'h0);
    chk({tag, "_d_hs"}, 32'(d_hs), 32'h1);
    chk({tag, "_d_vs"}, 32'(d_vs), 32'h1);
  endtask

  initial begin
    rst_n = 1'b0;
    dd_s  = 3'b000;
    dd_d  = 3'b101;
    n     = 0;
    repeat (3) @(posedge sysclk);
    #1 chk_reset_vals("rst");
    @(negedge sysclk);
    rst_n = 1'b1;
    start_run();
    run(3300);
    chk("hold101_count", 32'(hold_cnt), 32'(SHA * SVA));
    chk("fs_pulses", 32'(fs_cnt), 32'((3300 / 2 - 1) / SFRM + 1));
    chk("dflt_hs_fall1", 32'(d_f1), 32'd2);
    chk("dflt_hs_low", 32'(d_r1 - d_f1), 32'd192);
    chk("dflt_hs_period", 32'(d_f2 - d_f1), 32'd1600);
    chk("dflt_vs_fall", 32'(d_vf1), 32'd2);
    chk("dflt_vs_low", 32'(d_vr1 - d_vf1), 32'd3200);

    // Mid-operation reset must take effect before any clock edge.
    @(negedge sysclk);
    #1 rst_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    repeat (3) @(posedge sysclk);
    @(negedge sysclk);
    rst_n = 1'b1;
    start_run();
    run(600);
    chk("rerun_hs_fall1", 32'(d_f1), 32'd2);
    chk("rerun_hs_low", 32'(d_r1 - d_f1), 32'd192);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_SYNC, default 96: horizontal sync width, in pixel periods.
REQ-002 SHALL have parameter H_BP, default 48: horizontal back porch, in pixel periods.
REQ-003 SHALL have parameter H_ACTIVE, default 640: horizontal visible pixels.
REQ-004 SHALL have parameter H_TOTAL, default 800: pixel periods per line.
REQ-005 SHALL have parameter V_SYNC, default 2: vertical sync width, in lines.
REQ-006 SHALL have parameter V_BP, default 33: vertical back porch, in lines.
REQ-007 SHALL have parameter V_ACTIVE, default 480: visible lines.
REQ-008 SHALL have parameter V_TOTAL, default 525: lines per frame.
REQ-009 SHALL have port sysclk  input  1: single system clock, all logic on its rising edge.
REQ-010 SHALL have port rst_n  input  1: reset, asynchronous assert, active-low.
REQ-011 SHALL have port display_data  input  3: colour from the downstream GPU stage for the current display_addr.
REQ-012 SHALL have port display_addr  output  20: {h_count[9:0], v_count[9:0]}, driven to the GPU stage.
REQ-013 SHALL have port vga_hsync  output  1: horizontal sync, active-low.
REQ-014 SHALL have port vga_vsync  output  1: vertical sync, active-low.
REQ-015 SHALL have port vga_rgb  output  3: pixel colour to the DAC/pins.
REQ-016 SHALL have port frame_start  output  1: one-sysclk pulse at frame origin.

Function
REQ-017 SHALL toggle an internal pix_en each sysclk (0 immediately after reset, then 1, 0, 1 ...), giving pixel rate = sysclk/2.
REQ-018 SHALL advance h_count by 1 only on edges where pix_en=1; wrap H_TOTAL-1 -> 0.
REQ-019 SHALL increment v_count on the h_count wrap edge only; wrap V_TOTAL-1 -> 0 when both counters wrap together.
REQ-020 SHALL drive display_addr combinationally from the counters, each zero-extended to 10 bits; there is no extra latency.
REQ-021 SHALL define active = (H_SYNC+H_BP <= h_count < H_SYNC+H_BP+H_ACTIVE) AND (V_SYNC+V_BP <= v_count < V_SYNC+V_BP+V_ACTIVE), which is h 144..783 and v 35..514 at the defaults.
REQ-022 SHALL register vga_hsync = !(h_count < H_SYNC) on pix_en edges, using the pre-increment counter value.
REQ-023 SHALL register vga_vsync = !(v_count < V_SYNC) on pix_en edges, using the pre-increment counter value.
REQ-024 SHALL register vga_rgb = active ? display_data : 3'b000 on pix_en edges, so sync and colour stay aligned with one pixel period of latency from display_addr.
REQ-025 SHALL hold vga_hsync, vga_vsync and vga_rgb stable on non-pix_en edges.
REQ-026 SHALL assert frame_start for exactly one sysclk, on the pix_en edge where h_count=0 and v_count=0, and keep it 0 otherwise.
REQ-027 SHALL ignore display_data outside active, so X or garbage from the GPU stage never reaches vga_rgb.
REQ-028 SHALL size counters to 10 bits; parameter sets with H_TOTAL or V_TOTAL > 1024 are unsupported.

Reset
REQ-029 SHALL, while rst_n=0, force asynchronously: h_count=0, v_count=0, pix_en=0, vga_hsync=1, vga_vsync=1, vga_rgb=0, frame_start=0, display_addr=20'h00000.
REQ-030 SHALL, after rst_n rises, begin at pixel (0,0), with the first pix_en=1 edge on the second sysclk edge.
REQ-031 SHALL abandon the current line and frame on reset mid-operation, with no partial-state carry-over.

Verification
REQ-032 SHALL cover: reset, then run 2 lines -> vga_hsync low for 192 sysclk per line, falling edges 1600 sysclk apart.
REQ-033 SHALL cover: run 2 frames -> vga_vsync low for 3200 sysclk, falling edges 840000 sysclk apart.
REQ-034 SHALL cover: display_data held 3'b101 -> vga_rgb=3'b101 for exactly 307200 pixel periods per frame, only within h 144..783 and v 35..514, and 3'b000 elsewhere.
REQ-035 SHALL cover: counters at h=300, v=100 -> display_addr=20'h4B064; at h=799, v=524 the next pix step gives 20'h00000 and one frame_start pulse, with exactly one pulse per 840000 sysclk.
REQ-036 SHALL cover: rst_n pulsed low mid-line (h=400, v=200) -> outputs reach reset values without waiting for a clock edge, and timing restarts at (0,0) with first hsync fall 2 sysclk after release.
REQ-037 SHALL cover: display_data driven X outside the active window -> vga_rgb stays 3'b000, with no X propagation.
